nes_pad_reader: RTL and testbench

Reads the NES controller's serial shift register once per video frame and presents a debounced-by-frame, active-high 8-bit button vector to the game logic. It drives the pad's latch and clock lines, synchronises the pad's serial data line, and updates `buttons` atomically after all eight bits are captured. It sits between the controller connector pins and the game-state machine, which consumes `buttons` on `vSyncStart`.

---
 rtl/nes_pad_reader.sv | 168 ++++++++++++++++
 tb/tb_nes_pad_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_pad_reader.sv
// NES pad reader: latches the pad once per frame, shifts out 8 bits, publishes an active-high button vector.
// Latency: buttons/buttonsPressed/buttonsValid update LATCH_CYCLES + 14*HALF_CYCLES + 1 cycles after vSyncStart.
// Backpressure: none; vSyncStart pulses that arrive while a read is in progress are dropped, not queued.
module nes_pad_reader #(
    parameter int LATCH_CYCLES = 300,
    parameter int HALF_CYCLES  = 150,
    parameter int buttonA      = 0,
    parameter int buttonB      = 1,
    parameter int buttonSelect = 2,
    parameter int buttonStart  = 3,
    parameter int buttonUp     = 4,
    parameter int buttonDown   = 5,
    parameter int buttonLeft   = 6,
    parameter int buttonRight  = 7
) (
    input  logic       pixelClock,
    input  logic       reset,
    input  logic       vSyncStart,
    input  logic       nesData,
    output logic       nesLatch,
    output logic       nesClock,
    output logic [7:0] buttons,
    output logic [7:0] buttonsPressed,
    output logic       buttonsValid
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LATCH    = 3'd1,
        CLK_LOW  = 3'd2,
        CLK_HIGH = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Phase counters count down to zero, so they are loaded with length-1.
    localparam logic [15:0] LATCH_LOAD = 16'(LATCH_CYCLES - 1);
    localparam logic [15:0] HALF_LOAD  = 16'(HALF_CYCLES - 1);

    // Where each bit of the pad's shift order lands in the published vector.
    localparam int BIT_MAP [8] = '{buttonA, buttonB, buttonSelect, buttonStart,
                                   buttonUp, buttonDown, buttonLeft, buttonRight};

    state_t      state, state_nxt;
    logic [15:0] phase, phase_nxt;
    logic [2:0]  bit_cnt, bit_nxt;
    logic        sample;
    logic        finish;
    logic        sync_meta, sync_data;
    logic [7:0]  shift, shift_nxt;
    logic [7:0]  mapped;
    logic [7:0]  prev;

    // Two-flop synchroniser for the asynchronous pad data line; idles at "released".
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            sync_meta <= 1'b1;
            sync_data <= 1'b1;
        end else begin
            sync_meta <= nesData;
            sync_data <= sync_meta;
        end
    end

    // Next-state logic: walk latch, then seven low/high clock phases, sampling on each phase end.
    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        bit_nxt   = bit_cnt;
        sample    = 1'b0;
        finish    = 1'b0;
        case (state)
            // DONE is observably the first idle cycle, so a new frame may start there.
            IDLE, DONE: begin
                state_nxt = IDLE;
                if (vSyncStart) begin
                    state_nxt = LATCH;
                    phase_nxt = LATCH_LOAD;
                    bit_nxt   = 3'd0;
                end
            end
            LATCH: begin
                if (phase == 16'd0) begin
                    sample    = 1'b1;
                    state_nxt = CLK_LOW;
                    phase_nxt = HALF_LOAD;
                end else begin
                    phase_nxt = phase - 16'd1;
                end
            end
            CLK_LOW: begin
                if (phase == 16'd0) begin
                    state_nxt = CLK_HIGH;
                    phase_nxt = HALF_LOAD;
                end else begin
                    phase_nxt = phase - 16'd1;
                end
            end
            CLK_HIGH: begin
                if (phase == 16'd0) begin
                    sample    = 1'b1;
                    phase_nxt = HALF_LOAD;
                    if (bit_cnt == 3'd7) begin
                        state_nxt = DONE;
                        finish    = 1'b1;
                    end else begin
                        state_nxt = CLK_LOW;
                    end
                end else begin
                    phase_nxt = phase - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (sample) begin
            bit_nxt = bit_cnt + 3'd1;
        end
    end

    // Capture the current bit (inverted to active-high) and reorder into button positions.
    always_comb begin
        shift_nxt = shift;
        if (sample) begin
            shift_nxt[bit_cnt] = ~sync_data;
        end
        mapped = 8'h00;
        for (int i = 0; i < 8; i++) begin
            mapped[BIT_MAP[i][2:0]] = shift_nxt[i];
        end
    end

    // State, counters and pad pins; pins are registered from the next state so they never glitch.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            state    <= IDLE;
            phase    <= 16'd0;
            bit_cnt  <= 3'd0;
            shift    <= 8'h00;
            nesLatch <= 1'b0;
            nesClock <= 1'b1;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            bit_cnt  <= bit_nxt;
            shift    <= shift_nxt;
            nesLatch <= (state_nxt == LATCH);
            nesClock <= (state_nxt != CLK_LOW);
        end
    end

    // Publish the complete read atomically together with the newly-pressed edge mask.
    always_ff @(posedge pixelClock) begin
        if (reset) begin
            buttons        <= 8'h00;
            buttonsPressed <= 8'h00;
            buttonsValid   <= 1'b0;
            prev           <= 8'h00;
        end else if (finish) begin
            buttons        <= mapped;
            buttonsPressed <= mapped & ~prev;
            buttonsValid   <= 1'b1;
            prev           <= mapped;
        end else begin
            buttonsPressed <= 8'h00;
            buttonsValid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_nes_pad_reader.sv
// Bench for nes_pad_reader: behavioural pad, random frames, scoreboard of per-frame expectations.
// Latency: expects the result LATCH + 14*HALF + 1 cycles after each accepted vSyncStart.
// Backpressure: stimulus also injects vSyncStart during reads and mid-read resets.
module tb_nes_pad_reader;

    localparam int L        = 8;
    localparam int H        = 4;
    localparam int DONE_OFF = L + 14 * H + 1;

    logic       pixelClock = 1'b0;
    logic       reset      = 1'b1;
    logic       vSyncStart = 1'b0;
    logic       nesData;
    logic       nesLatch;
    logic       nesClock;
    logic [7:0] buttons;
    logic [7:0] buttonsPressed;
    logic       buttonsValid;

    nes_pad_reader #(.LATCH_CYCLES(L), .HALF_CYCLES(H)) dut (
        .pixelClock     (pixelClock),
        .reset          (reset),
        .vSyncStart     (vSyncStart),
        .nesData        (nesData),
        .nesLatch       (nesLatch),
        .nesClock       (nesClock),
        .buttons        (buttons),
        .buttonsPressed (buttonsPressed),
        .buttonsValid   (buttonsValid)
    );

    always #5 pixelClock = ~pixelClock;

    int cyc = 0;
    always @(posedge pixelClock) cyc <= cyc + 1;

    // ---------------- behavioural pad (active-low 8-bit shift register) ----------------
    logic [7:0] pad_word = 8'hFF;
    logic [7:0] pad_sr   = 8'hFF;
    logic       data_dly = 1'b1;
    bit         no_pad   = 1'b0;
    bit         dly_mode = 1'b0;

    always @(posedge nesClock or posedge nesLatch) begin
        if (nesLatch) pad_sr <= pad_word;
        else          pad_sr <= {1'b1, pad_sr[7:1]};
    end

    always @(posedge pixelClock) data_dly <= pad_sr[0];

    always_comb begin
        nesData = no_pad ? 1'b1 : (dly_mode ? data_dly : pad_sr[0]);
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        bit         exp_valid;
        logic [7:0] exp_b;
        logic [7:0] exp_p;
        int         rst_at;
        int         pulses;
    } desc_t;

    desc_t sb [256];
    int    wr_ptr = 0;
    bit    mark   = 1'b0;

    int total = 0;
    int bad   = 0;

    // ---------------- monitor (only process that compares) ----------------
    int         rd_ptr = 0;
    bit         active = 1'b0;
    desc_t      cur;
    int         cur_t0 = 0;
    int         lat_cnt = 0, lat_first = 0, lat_last = 0, pulse_cnt = 0;
    logic       clk_prev = 1'b1;
    logic       valid_prev = 1'b0;
    logic       rst_prev = 1'b1;
    logic [7:0] last_buttons = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    always @(negedge pixelClock) begin
        if (cyc == 2) begin
            chk("rst_latch", nesLatch, 0);
            chk("rst_clock", nesClock, 1);
            chk("rst_buttons", buttons, 0);
            chk("rst_pressed", buttonsPressed, 0);
            chk("rst_valid", buttonsValid, 0);
        end
        if (valid_prev) begin
            chk("valid_one_cycle", buttonsValid, 0);
            chk("pressed_clear", buttonsPressed, 0);
        end
        if (buttonsValid) begin
            chk("valid_timing", cyc,
                (active && cur.exp_valid) ? cur_t0 + DONE_OFF : -1);
        end
        if (cyc > 4 && buttons !== last_buttons) begin
            chk("buttons_change_only_on_update", buttonsValid | rst_prev, 1);
        end
        if (active) begin
            if (nesLatch) begin
                if (lat_cnt == 0) lat_first = cyc;
                lat_last = cyc;
                lat_cnt++;
            end
            if (!nesClock && clk_prev) pulse_cnt++;
            if (cur.rst_at > 0 && cyc == cur_t0 + cur.rst_at + 1) begin
                chk("abort_latch", nesLatch, 0);
                chk("abort_clock", nesClock, 1);
                chk("abort_buttons", buttons, 0);
            end
            if (cyc == cur_t0 + DONE_OFF) begin
                chk("frame_valid", buttonsValid, cur.exp_valid);
                if (cur.exp_valid) begin
                    chk("buttons", buttons, cur.exp_b);
                    chk("pressed", buttonsPressed, cur.exp_p);
                end
                chk("latch_cycles", lat_cnt, L);
                chk("latch_first", lat_first - cur_t0, 1);
                chk("latch_last", lat_last - cur_t0, L);
                chk("clock_pulses", pulse_cnt, cur.pulses);
                chk("clock_idle_high", nesClock, 1);
                active = 1'b0;
            end
        end
        if (mark) begin
            cur       = sb[rd_ptr];
            rd_ptr    = rd_ptr + 1;
            cur_t0    = cyc;
            lat_cnt   = 0;
            pulse_cnt = 0;
            lat_first = 0;
            lat_last  = 0;
            active    = 1'b1;
        end
        clk_prev     = nesClock;
        valid_prev   = buttonsValid;
        rst_prev     = reset;
        last_buttons = buttons;
    end

    // ---------------- stimulus + reference model ----------------
    logic [7:0] ref_prev = 8'h00;
    int         last_t0  = -100;

    task automatic to_cyc(input int n);
        while (cyc < n) begin
            @(posedge pixelClock);
            #1;
        end
    endtask

    // Number of nesClock low phases that have begun by cycle offset r.
    function automatic int pulses_before(input int r);
        int n = 0;
        for (int k = 1; k <= 7; k++)
            if (L + (2 * k - 2) * H + 1 <= r) n++;
        return n;
    endfunction

    task automatic frame(input logic [7:0] word, input bit np, input bit dl,
                         input int ign, input int rst_at, input bit b2b);
        desc_t      d;
        logic [7:0] pressed_now;
        int         t0;
        if (b2b) to_cyc(last_t0 + DONE_OFF);
        else     to_cyc(last_t0 + DONE_OFF + 4 + $urandom_range(0, 3));
        pad_word = word;
        no_pad   = np;
        dly_mode = dl;
        pressed_now = np ? 8'h00 : ~word;
        d.rst_at = rst_at;
        if (rst_at > 0) begin
            d.exp_valid = 1'b0;
            d.exp_b     = 8'h00;
            d.exp_p     = 8'h00;
            d.pulses    = pulses_before(rst_at);
            ref_prev    = 8'h00;
        end else begin
            d.exp_valid = 1'b1;
            d.exp_b     = pressed_now;
            d.exp_p     = pressed_now & ~ref_prev;
            d.pulses    = 7;
            ref_prev    = pressed_now;
        end
        sb[wr_ptr] = d;
        wr_ptr     = wr_ptr + 1;
        vSyncStart = 1'b1;
        mark       = 1'b1;
        t0         = cyc;
        @(posedge pixelClock);
        #1;
        vSyncStart = 1'b0;
        mark       = 1'b0;
        if (ign > 0) begin
            to_cyc(t0 + ign);
            vSyncStart = 1'b1;
            @(posedge pixelClock);
            #1;
            vSyncStart = 1'b0;
        end
        if (rst_at > 0) begin
            to_cyc(t0 + rst_at);
            reset = 1'b1;
            @(posedge pixelClock);
            #1;
            reset = 1'b0;
        end
        last_t0 = t0;
    endtask

    initial begin
        repeat (4) @(posedge pixelClock);
        #1;
        reset = 1'b0;
        to_cyc(cyc + 2);
        frame(8'b11110110, 0, 0, 0,  0, 0);   // A+Start, first read: all held show pressed
        frame(8'h77,       0, 0, 20, 0, 0);   // Start+Right, extra vSyncStart mid-read
        frame(8'h77,       1, 0, 0,  0, 0);   // pad unplugged
        frame(8'hF6,       0, 0, 0,  0, 0);   // buttons back to 09
        frame(8'h00,       0, 0, 0, 30, 0);   // reset mid-read
        frame(8'hF6,       0, 0, 0,  0, 0);   // full read after reset, prev cleared
        frame(8'($urandom), 0, 1, 0, 0, 0);   // pad data lags the shift edge by a cycle
        frame(8'($urandom), 0, 1, 0, 0, 1);   // back-to-back frame started in the DONE cycle
        for (int n = 0; n < 16; n++) begin
            bit np, dl, b2b;
            int ign, rst_at;
            np     = ($urandom_range(0, 7) == 0);
            dl     = $urandom_range(0, 1) == 1;
            b2b    = ($urandom_range(0, 3) == 0);
            rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(L, 60) : 0;
            ign    = (rst_at == 0 && $urandom_range(0, 2) == 0) ? $urandom_range(1, 60) : 0;
            frame(8'($urandom), np, dl, ign, rst_at, b2b);
        end
        to_cyc(last_t0 + DONE_OFF + 4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
